// File: rtl/shift_sub_div.sv
// rtl/shift_sub_div.sv - signed fixed-point divider, restoring shift-subtract, one quotient bit per clock
module shift_sub_div #(
    parameter int BITS  = 17,
    parameter int NFRAC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] quotient,
    output logic            div_zero,
    output logic            ovf
);
    localparam int N  = BITS + NFRAC;
    localparam int CW = $clog2(N);
    localparam logic [N-1:0]    POS_MAX = N'((64'd1 << (BITS - 1)) - 64'd1);
    localparam logic [N-1:0]    NEG_MAX = N'(64'd1 << (BITS - 1));
    localparam logic [BITS-1:0] Q_POS   = {1'b0, {(BITS - 1){1'b1}}};
    localparam logic [BITS-1:0] Q_NEG   = {1'b1, {(BITS - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;
    state_t state, state_nx;

    // num starts as |dividend|<<NFRAC; quotient bits shift in at the LSB as it drains
    logic [N-1:0]    num;
    logic [BITS:0]   den;
    logic [BITS:0]   rem;
    logic [CW-1:0]   cnt;
    logic            sign_dd;
    logic            sign_dv;
    logic            dz_r;

    logic            accept;
    logic [BITS-1:0] dd_abs;
    logic [BITS-1:0] dv_abs;
    logic [BITS+1:0] rem_sh;
    logic [BITS+1:0] rem_sub;
    logic            rem_ge;
    logic            res_neg;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // BITS-wide unsigned magnitudes hold 2^(BITS-1) exactly
    assign dd_abs  = dividend[BITS-1] ? (~dividend + BITS'(1)) : dividend;
    assign dv_abs  = divisor[BITS-1] ? (~divisor + BITS'(1)) : divisor;
    assign rem_sh  = {rem, num[N-1]};
    assign rem_sub = rem_sh - {1'b0, den};
    assign rem_ge  = ~rem_sub[BITS+1];
    assign res_neg = (sign_dd ^ sign_dv) && (num != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (divisor == '0) ? FINAL : CALC;
            CALC:    if (cnt == CW'(N - 1)) state_nx = FINAL;
            FINAL:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num      <= '0;
            den      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_dd  <= 1'b0;
            sign_dv  <= 1'b0;
            dz_r     <= 1'b0;
            quotient <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_dd <= dividend[BITS-1];
                        sign_dv <= divisor[BITS-1];
                        dz_r    <= (divisor == '0);
                        num     <= {dd_abs, {NFRAC{1'b0}}};
                        den     <= {1'b0, dv_abs};
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    num <= {num[N-2:0], rem_ge};
                    rem <= rem_ge ? rem_sub[BITS:0] : rem_sh[BITS:0];
                    cnt <= cnt + CW'(1);
                end
                FINAL: begin
                    div_zero <= dz_r;
                    if (dz_r) begin
                        quotient <= sign_dd ? Q_NEG : Q_POS;
                        ovf      <= 1'b0;
                    end else if (res_neg) begin
                        if (num > NEG_MAX) begin
                            quotient <= Q_NEG;
                            ovf      <= 1'b1;
                        end else begin
                            quotient <= ~num[BITS-1:0] + BITS'(1);
                            ovf      <= 1'b0;
                        end
                    end else begin
                        if (num > POS_MAX) begin
                            quotient <= Q_POS;
                            ovf      <= 1'b1;
                        end else begin
                            quotient <= num[BITS-1:0];
                            ovf      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sub_div.sv
// tb/tb_shift_sub_div.sv - self-checking bench for shift_sub_div against an arithmetic reference model
module tb_shift_sub_div;
    localparam int BITS  = 17;
    localparam int NFRAC = 8;
    localparam int N     = BITS + NFRAC;
    localparam int QMAX  = (1 << (BITS - 1)) - 1;
    localparam int QMIN  = -(1 << (BITS - 1));

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] dividend;
    logic [BITS-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] quotient;
    logic            div_zero;
    logic            ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_sub_div #(.BITS(BITS), .NFRAC(NFRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    // Reference: real fixed-point division, truncate toward zero, then clamp
    function automatic void model(input int a, input int b, output int q, output bit dz, output bit ov);
        longint r;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            q  = (a >= 0) ? QMAX : QMIN;
        end else begin
            r = (longint'(a) * (longint'(1) << NFRAC)) / longint'(b);
            if (r > QMAX) begin
                r  = QMAX;
                ov = 1'b1;
            end else if (r < QMIN) begin
                r  = QMIN;
                ov = 1'b1;
            end
            q = int'(r);
        end
    endfunction

    task automatic start_op(input int a, input int b);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = BITS'(a);
        divisor  = BITS'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = BITS'($urandom);
        divisor  = BITS'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (out_valid !== 1'b1 && lat < 200);
        if (out_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: out_valid=%b after %0d edges, required 1", out_valid, lat);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, quotient, div_zero, ovf} !== {1'b1, 1'b0, {BITS{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: rdy=%b vld=%b q=%h dz=%b ovf=%b, required 1 0 0 0 0",
                     in_ready, out_valid, quotient, div_zero, ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int ta[6]  = '{768, -256, 5, -5, 65535, -65536};
        int tb[6]  = '{512, 768, 0, 0, 1, -256};
        int tq[6]  = '{384, -85, 65535, -65536, 65535, 65535};
        bit tdz[6] = '{0, 0, 1, 1, 0, 0};
        bit tov[6] = '{0, 0, 0, 0, 1, 1};
        int tl[6]  = '{N + 1, N + 1, 1, 1, N + 1, N + 1};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(lat);
            n_tests++;
            if (quotient !== BITS'(tq[i]) || div_zero !== tdz[i] || ovf !== tov[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: %0d/%0d got q=%0d dz=%b ovf=%b, required q=%0d dz=%b ovf=%b",
                         i, ta[i], tb[i], $signed(quotient), div_zero, ovf, tq[i], tdz[i], tov[i]);
            end
            n_tests++;
            if (lat != tl[i]) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d edges, required %0d", i, lat, tl[i]);
            end
            handshake();
        end
    endtask

    task automatic test_random();
        logic signed [BITS-1:0] ra;
        logic signed [BITS-1:0] rb;
        int q;
        bit dz;
        bit ov;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = BITS'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = BITS'($urandom_range(1, 300) * (($urandom_range(0, 1) == 1) ? -1 : 1));
                default: rb = BITS'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) ra = BITS'(int'(ra) / 64);
            model(int'(ra), int'(rb), q, dz, ov);
            start_op(int'(ra), int'(rb));
            wait_done(lat);
            n_tests++;
            if (quotient !== BITS'(q) || div_zero !== dz || ovf !== ov || lat != ((rb == 0) ? 1 : N + 1)) begin
                n_fail++;
                $display("FAIL random_%0d: %0d/%0d got q=%0d dz=%b ovf=%b lat=%0d, required q=%0d dz=%b ovf=%b",
                         i, ra, rb, $signed(quotient), div_zero, ovf, lat, q, dz, ov);
            end
            handshake();
        end
    endtask

    task automatic test_stall();
        int q;
        bit dz;
        bit ov;
        int lat;
        model(1000, -300, q, dz, ov);
        start_op(1000, -300);
        wait_done(lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'(c % 2 == 0);
            dividend = BITS'($urandom);
            divisor  = BITS'($urandom);
            @(posedge clk);
            #1;
            n_tests++;
            if (quotient !== BITS'(q) || div_zero !== dz || ovf !== ov || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: q=%0d dz=%b ovf=%b vld=%b rdy=%b, required q=%0d dz=%b ovf=%b vld=1 rdy=0",
                         c, $signed(quotient), div_zero, ovf, out_valid, in_ready, q, dz, ov);
            end
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_overlap: rdy=%b, required 1 (no accept on handshake edge)", in_ready);
        end
        start_op(-768, 512);
        wait_done(lat);
        n_tests++;
        if (quotient !== BITS'(-384) || div_zero !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL after_stall: q=%0d dz=%b ovf=%b, required -384 0 0", $signed(quotient), div_zero, ovf);
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        start_op(768, 512);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_valid, quotient, div_zero, ovf} !== {1'b1, 1'b0, {BITS{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_reset: rdy=%b vld=%b q=%h dz=%b ovf=%b, required 1 0 0 0 0",
                     in_ready, out_valid, quotient, div_zero, ovf);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_result: out_valid high %0d cycles, required 0", seen);
        end
        start_op(768, 512);
        wait_done(lat);
        n_tests++;
        if (quotient !== BITS'(384) || div_zero !== 1'b0 || ovf !== 1'b0 || lat != N + 1) begin
            n_fail++;
            $display("FAIL abort_recover: q=%0d dz=%b ovf=%b lat=%0d, required 384 0 0 %0d",
                     $signed(quotient), div_zero, ovf, lat, N + 1);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/shift_sub_div.md
SHIFT_SUB_DIV -- requirements
Module: shift_sub_div

Interface
REQ-001 The block SHALL expose parameter BITS, default 17, meaning the width of operands and quotient.
REQ-002 The block SHALL expose parameter NFRAC, default 8, meaning the number of fractional bits shared by dividend, divisor and quotient (signed fixed point).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk SHALL be an input, 1 bit wide, the rising-edge clock.
REQ-005 Port reset SHALL be an input, 1 bit wide, the asynchronous active-high reset.
REQ-006 Port in_valid SHALL be an input, 1 bit wide, indicating operands are present.
REQ-007 Port in_ready SHALL be an output, 1 bit wide, indicating the block accepts operands.
REQ-008 Port dividend SHALL be an input, BITS wide, a signed fixed-point numerator.
REQ-009 Port divisor SHALL be an input, BITS wide, a signed fixed-point denominator.
REQ-010 Port out_valid SHALL be an output, 1 bit wide, indicating the result is valid.
REQ-011 Port out_ready SHALL be an input, 1 bit wide, indicating the consumer accepts the result.
REQ-012 Port quotient SHALL be an output, BITS wide, the signed fixed-point result.
REQ-013 Port div_zero SHALL be an output, 1 bit wide, set when divisor==0.
REQ-014 Port ovf SHALL be an output, 1 bit wide, set when the result was saturated.

Function
REQ-015 The FSM SHALL have states IDLE, CALC, FINAL and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 An accept occurs when in_valid&&in_ready at a rising edge; the block SHALL register the sign, |dividend|<<NFRAC and |divisor|, with magnitudes BITS+1 wide so that -2^(BITS-1) is exact.
REQ-018 On an accept with divisor!=0, the FSM SHALL go to CALC; with divisor==0, it SHALL go directly to FINAL.
REQ-019 CALC SHALL perform restoring shift-subtract division, one quotient bit per edge, MSB first, for exactly N=BITS+NFRAC edges, then go to FINAL.
REQ-020 FINAL SHALL apply sign, saturation and flags, register quotient/div_zero/ovf, and go to DONE.
REQ-021 Latency from the accept edge to out_valid SHALL be N+1 edges in the nonzero case and 1 edge in the div-by-zero case.
REQ-022 Rounding SHALL truncate toward zero.
REQ-023 A positive result SHALL saturate at 2^(BITS-1)-1, and a negative result SHALL saturate at -2^(BITS-1); ovf=1 iff saturation occurred.
REQ-024 When divisor==0, the result SHALL be quotient = 2^(BITS-1)-1 if dividend>=0, else -2^(BITS-1), with div_zero=1 and ovf=0.
REQ-025 Result signs SHALL be: negative iff operand signs differ and the magnitude is nonzero; a zero result SHALL have no negative zero.
REQ-026 In DONE, quotient, div_zero and ovf SHALL hold stable until out_valid&&out_ready, after which the FSM SHALL return to IDLE on that edge.
REQ-027 There SHALL be no overlap: a new accept is possible no earlier than the edge after the output handshake.
REQ-028 Operand inputs SHALL be ignored outside accept edges; changes during CALC SHALL have no effect.

Reset
REQ-029 While reset=1, the state SHALL be IDLE and the outputs SHALL be in_ready=1, out_valid=0, quotient=0, div_zero=0, ovf=0, independent of clk.
REQ-030 Reset asserted in CALC, FINAL or DONE SHALL abort the operation with no result emitted; the first accept after deassertion SHALL behave as from power-up.

Verification (BITS=17, NFRAC=8; 1.0=256)
REQ-031 The bench SHALL check: dividend=768, divisor=512 -> quotient=384, flags 0, out_valid exactly 26 edges after accept.
REQ-032 The bench SHALL check: dividend=-256, divisor=768 -> quotient=-85 (truncation toward zero), flags 0.
REQ-033 The bench SHALL check: dividend=5, divisor=0 -> quotient=65535, div_zero=1, out_valid 1 edge after accept; dividend=-5, divisor=0 -> quotient=-65536.
REQ-034 The bench SHALL check: dividend=65535, divisor=1 -> quotient=65535, ovf=1; dividend=-65536, divisor=-256 -> quotient=65535, ovf=1.
REQ-035 The bench SHALL check: out_ready held 0 for 5 cycles in DONE -> quotient/flags stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next edge.
REQ-036 The bench SHALL check: reset pulsed at CALC edge 10 -> outputs immediately at reset values, no out_valid; a subsequent 768/512 -> 384.
